// File: rtl/fpu_addsub_issue_ctrl.sv
// ---------------------------------------------------------------------------
// fpu_addsub_issue_ctrl
//
// Issue/retire controller wrapped around the fixed-latency add_sub_main
// pipeline. Requests are accepted on a valid/ready handshake and forwarded to
// the pipeline. A valid shift register follows each operation through the
// pipeline. Results are captured into a show-ahead FIFO and presented on a
// valid/ready handshake. The pipeline cannot stall, so credits are taken at
// issue time. An operation is only issued when a FIFO slot is guaranteed for
// its result.
//
// Optional feature: define FPU_ADDSUB_TAG_EN to add in_tag/out_tag. With it, a
// user tag travels alongside each operation and is returned with the result.
//
// Ports:
//   clk, arst_n          clock, asynchronous active-low reset
//   flush                synchronous discard of everything in flight/buffered
//   in_valid/in_ready    request handshake, operands in_a/in_b, in_op (1=sub)
//   in_tag               request tag (FPU_ADDSUB_TAG_EN only)
//   pipe_en/a/b/op       drive add_sub_main en/a/b/operation_select
//   pipe_r               add_sub_main R, valid LATENCY cycles after pipe_en
//   out_valid/out_ready  result handshake, out_r = FIFO head result
//   out_tag              FIFO head tag (FPU_ADDSUB_TAG_EN only)
//   busy                 any operation in flight or buffered
// ---------------------------------------------------------------------------
module fpu_addsub_issue_ctrl #(
  parameter int WIDTH   = 32,
  parameter int LATENCY = 5,
  parameter int DEPTH   = 4,
  parameter int TAG_W   = 4
) (
  input  logic             clk,
  input  logic             arst_n,
  input  logic             flush,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_a,
  input  logic [WIDTH-1:0] in_b,
  input  logic             in_op,
`ifdef FPU_ADDSUB_TAG_EN
  input  logic [TAG_W-1:0] in_tag,
  output logic [TAG_W-1:0] out_tag,
`endif
  output logic             pipe_en,
  output logic [WIDTH-1:0] pipe_a,
  output logic [WIDTH-1:0] pipe_b,
  output logic             pipe_op,
  input  logic [WIDTH-1:0] pipe_r,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_r,
  output logic             busy
);

  localparam int PW = $clog2(DEPTH);
  localparam int CW = $clog2(DEPTH + 1);
  localparam int IW = $clog2(LATENCY + 1);

  // Elaboration-time parameter sanity checks.
  if (DEPTH < 2 || (DEPTH & (DEPTH - 1)) != 0) begin : g_bad_depth
    $error("DEPTH must be a power of 2 and >= 2");
  end
  if (LATENCY < 1) begin : g_bad_latency
    $error("LATENCY must be >= 1");
  end
  if (TAG_W < 1) begin : g_bad_tag_w
    $error("TAG_W must be >= 1");
  end

  logic [LATENCY-1:0] vsr;
  logic [IW-1:0]      inflight;
  logic [CW-1:0]      count;
  logic [PW-1:0]      wr_ptr;
  logic [PW-1:0]      rd_ptr;
  logic [WIDTH-1:0]   mem [DEPTH];
  logic               issue;
  logic               push;
  logic               pop;

  // -------------------------------------------------------------------------
  // Issue side
  // -------------------------------------------------------------------------
  assign issue   = in_valid && in_ready && !flush;
  assign pipe_en = issue;
  assign pipe_a  = issue ? in_a : '0;
  assign pipe_b  = issue ? in_b : '0;
  assign pipe_op = issue && in_op;

  // NOTE: every variable written in always_comb gets a default first, so no
  // path leaves it unassigned and no latch is inferred.
  always_comb begin
    inflight = '0;
    for (int i = 0; i < LATENCY; i++) begin
      inflight = inflight + IW'(vsr[i]);
    end
  end

  // Credits cover buffered plus in-flight results. A pop in this cycle is
  // not credited until the next cycle, so the check stays conservative.
  assign in_ready = (32'(count) + 32'(inflight)) < 32'(DEPTH);

  // -------------------------------------------------------------------------
  // Retire side
  // -------------------------------------------------------------------------
  assign push      = vsr[LATENCY-1];
  assign out_valid = (count != '0);
  assign pop       = out_valid && out_ready;
  assign busy      = (inflight != '0) || (count != '0);

  // Gate with out_valid so the head reads 0 while the FIFO is empty.
  assign out_r = out_valid ? mem[rd_ptr] : '0;

  // NOTE: sequential state uses non-blocking assignments only. All flops then
  // sample the values from before the edge, whatever order the statements are in.
  always_ff @(posedge clk or negedge arst_n) begin
    if (!arst_n) begin
      vsr    <= '0;
      count  <= '0;
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else if (flush) begin
      // Pipeline results already launched still appear on pipe_r. Their valid
      // bits are dropped here, so they are never written.
      vsr    <= '0;
      count  <= '0;
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else begin
      // Shift left and insert issue at bit 0. The cast drops the oldest bit.
      vsr <= LATENCY'({vsr, issue});
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop)  rd_ptr <= rd_ptr + 1'b1;
      if (push && !pop)      count <= count + 1'b1;
      else if (pop && !push) count <= count - 1'b1;
    end
  end

  // NOTE: the FIFO storage has no reset. Entries are only read while count
  // says they are valid, so resetting the array would add cost and change nothing.
  always_ff @(posedge clk) begin
    if (push && !flush) mem[wr_ptr] <= pipe_r;
  end

`ifdef FPU_ADDSUB_TAG_EN
  // -------------------------------------------------------------------------
  // Tag path: shifts in step with vsr and is stored next to the result.
  // -------------------------------------------------------------------------
  logic [TAG_W-1:0] tsr  [LATENCY];
  logic [TAG_W-1:0] tmem [DEPTH];

  always_ff @(posedge clk or negedge arst_n) begin
    if (!arst_n) begin
      for (int i = 0; i < LATENCY; i++) tsr[i] <= '0;
    end else if (flush) begin
      for (int i = 0; i < LATENCY; i++) tsr[i] <= '0;
    end else begin
      tsr[0] <= issue ? in_tag : '0;
      for (int i = 1; i < LATENCY; i++) tsr[i] <= tsr[i-1];
    end
  end

  always_ff @(posedge clk) begin
    if (push && !flush) tmem[wr_ptr] <= tsr[LATENCY-1];
  end

  assign out_tag = out_valid ? tmem[rd_ptr] : '0;
`endif

endmodule

// File: tb/tb_fpu_addsub_issue_ctrl.sv
// ---------------------------------------------------------------------------
// tb_fpu_addsub_issue_ctrl
//
// Self-checking bench for fpu_addsub_issue_ctrl. A behavioural stand-in for
// add_sub_main (float add/sub through a LATENCY-deep delay line) drives pipe_r.
// A reference model predicts every cycle's outputs. It keeps a queue of
// unretired operations, each with its issue cycle. An operation is visible at
// the head from issue cycle + LATENCY + 1. A request is accepted while fewer
// than DEPTH operations are outstanding.
// ---------------------------------------------------------------------------
module tb_fpu_addsub_issue_ctrl;

  localparam int W     = 32;
  localparam int LAT   = 5;
  localparam int DEPTH = 4;
  localparam int TW    = 4;

  logic          clk = 1'b0;
  logic          arst_n;
  logic          flush, in_valid, in_op, out_ready;
  logic [W-1:0]  in_a, in_b;
  logic [TW-1:0] tag_drv;
  logic          in_ready, pipe_en, pipe_op, out_valid, busy;
  logic [W-1:0]  pipe_a, pipe_b, pipe_r, out_r;
`ifdef FPU_ADDSUB_TAG_EN
  logic [TW-1:0] out_tag;
`endif

  int total = 0;
  int bad   = 0;
  int now   = 0;

  always #5 clk = ~clk;
  always @(posedge clk) now <= now + 1;

  fpu_addsub_issue_ctrl #(.WIDTH(W), .LATENCY(LAT), .DEPTH(DEPTH), .TAG_W(TW)) dut (
    .clk(clk), .arst_n(arst_n), .flush(flush),
    .in_valid(in_valid), .in_ready(in_ready), .in_a(in_a), .in_b(in_b), .in_op(in_op),
`ifdef FPU_ADDSUB_TAG_EN
    .in_tag(tag_drv), .out_tag(out_tag),
`endif
    .pipe_en(pipe_en), .pipe_a(pipe_a), .pipe_b(pipe_b), .pipe_op(pipe_op), .pipe_r(pipe_r),
    .out_valid(out_valid), .out_ready(out_ready), .out_r(out_r), .busy(busy)
  );

  // ---------------- single-precision helpers (exact for small values) -----
  function automatic real f2r(input logic [31:0] x);
    logic [63:0] d;
    if (x[30:23] == 8'd0) return 0.0;
    d = {x[31], 11'(int'(x[30:23]) - 127 + 1023), x[22:0], 29'd0};
    return $bitstoreal(d);
  endfunction

  function automatic logic [31:0] r2f(input real r);
    logic [63:0] d;
    if (r == 0.0) return 32'd0;
    d = $realtobits(r);
    return {d[63], 8'(int'(d[62:52]) - 1023 + 127), d[51:29]};
  endfunction

  function automatic logic [31:0] fadd(input logic [31:0] a, input logic [31:0] b, input logic op);
    return r2f(op ? f2r(a) - f2r(b) : f2r(a) + f2r(b));
  endfunction

  // ---------------- add_sub_main stand-in --------------------------------
  logic [W-1:0] stage [LAT];
  always @(posedge clk) begin
    stage[0] <= fadd(pipe_a, pipe_b, pipe_op);
    for (int i = 1; i < LAT; i++) stage[i] <= stage[i-1];
  end
  assign pipe_r = stage[LAT-1];

  // ---------------- reference model ---------------------------------------
  typedef struct {
    int          cyc;
    logic [31:0] res;
    logic [3:0]  tag;
  } op_t;

  typedef struct packed {
    logic        rdy;
    logic        en;
    logic        op;
    logic        ov;
    logic        busy;
    logic [31:0] a;
    logic [31:0] b;
    logic [31:0] r;
    logic [3:0]  tag;
  } snap_t;

  op_t         q[$];
  logic [31:0] popped[$];
  logic [3:0]  popped_tag[$];
  snap_t       obs, exp;

  // Drive one cycle of inputs, capture DUT outputs and model predictions, and
  // advance the model. Comparisons are made by the calling scenario.
  task automatic step(input logic v, input logic [31:0] a, input logic [31:0] b,
                      input logic op, input logic ordy, input logic fl, input logic [3:0] tag);
    @(negedge clk);
    in_valid = v; in_a = a; in_b = b; in_op = op;
    out_ready = ordy; flush = fl; tag_drv = tag;
    #1;
    exp      = '0;
    exp.rdy  = (q.size() < DEPTH);
    exp.en   = v && exp.rdy && !fl;
    exp.op   = exp.en && op;
    exp.a    = exp.en ? a : 32'd0;
    exp.b    = exp.en ? b : 32'd0;
    exp.busy = (q.size() != 0);
    if (q.size() != 0 && now >= q[0].cyc + LAT + 1) begin
      exp.ov = 1'b1;
      exp.r  = q[0].res;
`ifdef FPU_ADDSUB_TAG_EN
      exp.tag = q[0].tag;
`endif
    end
    obs = '0;
    obs.rdy = in_ready; obs.en = pipe_en; obs.op = pipe_op; obs.ov = out_valid;
    obs.busy = busy; obs.a = pipe_a; obs.b = pipe_b; obs.r = out_r;
`ifdef FPU_ADDSUB_TAG_EN
    obs.tag = out_tag;
`endif
    if (obs.ov && ordy) begin
      popped.push_back(obs.r);
      popped_tag.push_back(obs.tag);
    end
    if (exp.ov && ordy) void'(q.pop_front());
    if (exp.en) q.push_back('{now, fadd(a, b, op), tag});
    if (fl) q.delete();
  endtask

  // ---------------- scenarios ---------------------------------------------
  task automatic test_reset();
    arst_n = 1'b0; flush = 0; in_valid = 0; in_a = 0; in_b = 0; in_op = 0;
    out_ready = 0; tag_drv = 0;
    #1;
    if (in_ready !== 1'b1)  begin bad++; $display("FAIL reset_in_ready got=%b want=1", in_ready); end
    total++;
    if (out_valid !== 1'b0) begin bad++; $display("FAIL reset_out_valid got=%b want=0", out_valid); end
    total++;
    if (busy !== 1'b0)      begin bad++; $display("FAIL reset_busy got=%b want=0", busy); end
    total++;
    if (out_r !== 32'd0)    begin bad++; $display("FAIL reset_out_r got=%h want=0", out_r); end
    total++;
    if (pipe_en !== 1'b0)   begin bad++; $display("FAIL reset_pipe_en got=%b want=0", pipe_en); end
    total++;
    repeat (2) @(negedge clk);
    arst_n = 1'b1;
  endtask

  task automatic test_single_add();
    step(1, 32'h3F800000, 32'h40000000, 0, 1, 0, 0);
    if (obs !== exp) begin bad++; $display("FAIL add_issue got=%h want=%h", obs, exp); end
    total++;
    for (int k = 1; k <= LAT + 2; k++) begin
      step(0, 0, 0, 0, 1, 0, 0);
      if (obs !== exp) begin bad++; $display("FAIL add_cyc%0d got=%h want=%h", k, obs, exp); end
      total++;
      if (k == LAT && obs.ov !== 1'b0) begin
        bad++; $display("FAIL add_early got=%b want=0", obs.ov);
      end
      if (k == LAT + 1 && {obs.ov, obs.r} !== {1'b1, 32'h40400000}) begin
        bad++; $display("FAIL add_result got=%b/%h want=1/40400000", obs.ov, obs.r);
      end
      if (k == LAT + 2 && obs.busy !== 1'b0) begin
        bad++; $display("FAIL add_busy_clear got=%b want=0", obs.busy);
      end
      if (k >= LAT) total++;
    end
  endtask

  task automatic test_single_sub();
    popped.delete();
    step(1, 32'h40400000, 32'h3F800000, 1, 1, 0, 0);
    if (obs !== exp) begin bad++; $display("FAIL sub_issue got=%h want=%h", obs, exp); end
    total++;
    for (int k = 1; k <= LAT + 2; k++) begin
      step(0, 32'h12345678, 32'h9ABCDEF0, 1, 1, 0, 0);
      if (obs !== exp) begin bad++; $display("FAIL sub_cyc%0d got=%h want=%h", k, obs, exp); end
      total++;
      if (k == 1 && {obs.a, obs.b} !== 64'd0) begin
        bad++; $display("FAIL sub_pipe_idle got=%h/%h want=0/0", obs.a, obs.b);
      end
      if (k == 1) total++;
    end
    if (popped.size() != 1 || popped[0] !== 32'h40000000) begin
      bad++; $display("FAIL sub_result count=%0d first=%h want=1/40000000",
                      popped.size(), popped.size() ? popped[0] : 32'hx);
    end
    total++;
  endtask

  task automatic test_back_to_back();
    int          n      = 1;
    int          issued = 0;
    logic [31:0] want [5] = '{32'h40000000, 32'h40800000, 32'h40C00000, 32'h41000000, 32'h41200000};
    popped.delete();
    for (int k = 0; k < 12; k++) begin
      step(1, r2f(real'(n)), r2f(real'(n)), 0, 0, 0, 0);
      if (obs !== exp) begin bad++; $display("FAIL b2b_cyc%0d got=%h want=%h", k, obs, exp); end
      total++;
      if (obs.en) begin issued++; n++; end
    end
    if (issued != 4 || obs.rdy !== 1'b0) begin
      bad++; $display("FAIL b2b_credit issued=%0d in_ready=%b want=4/0", issued, obs.rdy);
    end
    total++;
    step(1, r2f(real'(n)), r2f(real'(n)), 0, 1, 0, 0);
    if (obs !== exp) begin bad++; $display("FAIL b2b_pop got=%h want=%h", obs, exp); end
    total++;
    step(1, r2f(real'(n)), r2f(real'(n)), 0, 0, 0, 0);
    if (obs.en !== 1'b1) begin bad++; $display("FAIL b2b_resume got=%b want=1", obs.en); end
    total++;
    for (int k = 0; k < LAT + 8; k++) begin
      step(0, 0, 0, 0, 1, 0, 0);
      if (obs !== exp) begin bad++; $display("FAIL b2b_drain%0d got=%h want=%h", k, obs, exp); end
      total++;
    end
    for (int i = 0; i < 5; i++) begin
      if (i >= popped.size() || popped[i] !== want[i]) begin
        bad++; $display("FAIL b2b_order%0d got=%h want=%h", i,
                        i < popped.size() ? popped[i] : 32'hx, want[i]);
      end
      total++;
    end
  endtask

  task automatic test_stream();
    logic [31:0] ea[8], eb[8], want[8];
    logic        eop[8];
    int          sent = 0;
    for (int i = 0; i < 8; i++) begin
      ea[i]   = r2f(real'($urandom_range(1, 16)));
      eb[i]   = r2f(real'($urandom_range(1, 16)));
      eop[i]  = 1'($urandom_range(0, 1));
      want[i] = r2f(eop[i] ? f2r(ea[i]) - f2r(eb[i]) : f2r(ea[i]) + f2r(eb[i]));
    end
    popped.delete();
    for (int k = 0; k < 40; k++) begin
      if (sent < 8) step(1, ea[sent], eb[sent], eop[sent], 1, 0, 0);
      else          step(0, 0, 0, 0, 1, 0, 0);
      if (obs !== exp) begin bad++; $display("FAIL stream_cyc%0d got=%h want=%h", k, obs, exp); end
      total++;
      if (obs.en) sent++;
    end
    if (popped.size() != 8) begin
      bad++; $display("FAIL stream_count got=%0d want=8", popped.size());
    end
    total++;
    for (int i = 0; i < 8 && i < popped.size(); i++) begin
      if (popped[i] !== want[i]) begin
        bad++; $display("FAIL stream_res%0d got=%h want=%h", i, popped[i], want[i]);
      end
      total++;
    end
  endtask

  task automatic test_flush();
    logic seen = 1'b0;
    popped.delete();
    for (int k = 0; k < 3; k++) step(1, r2f(real'(k + 1)), 32'h3F800000, 0, 1, 0, 0);
    step(0, 0, 0, 0, 1, 0, 0);
    step(1, 32'h40000000, 32'h40000000, 0, 1, 1, 0);
    if (obs.en !== 1'b0) begin bad++; $display("FAIL flush_no_issue got=%b want=0", obs.en); end
    total++;
    step(0, 0, 0, 0, 1, 0, 0);
    if ({obs.rdy, obs.busy} !== 2'b10) begin
      bad++; $display("FAIL flush_after rdy/busy got=%b%b want=10", obs.rdy, obs.busy);
    end
    total++;
    for (int k = 0; k < LAT + 3; k++) begin
      step(0, 0, 0, 0, 1, 0, 0);
      if (obs !== exp) begin bad++; $display("FAIL flush_cyc%0d got=%h want=%h", k, obs, exp); end
      total++;
      seen |= obs.ov;
    end
    if (seen !== 1'b0) begin bad++; $display("FAIL flush_discard out_valid seen=%b want=0", seen); end
    total++;
    step(1, 32'h40E00000, 32'h40000000, 1, 1, 0, 0);
    for (int k = 0; k < LAT + 3; k++) step(0, 0, 0, 0, 1, 0, 0);
    if (popped.size() != 1 || popped[0] !== 32'h40A00000) begin
      bad++; $display("FAIL flush_fresh count=%0d first=%h want=1/40a00000",
                      popped.size(), popped.size() ? popped[0] : 32'hx);
    end
    total++;
  endtask

  task automatic test_reset_mid();
    popped.delete();
    step(1, 32'h3F800000, 32'h3F800000, 0, 0, 0, 0);
    step(1, 32'h40000000, 32'h40000000, 0, 0, 0, 0);
    for (int k = 0; k < LAT; k++) step(0, 0, 0, 0, 0, 0, 0);
    step(1, 32'h40400000, 32'h40400000, 0, 0, 0, 0);
    step(1, 32'h40800000, 32'h40800000, 0, 0, 0, 0);
    step(0, 0, 0, 0, 0, 0, 0);
    if ({obs.ov, obs.busy, obs.rdy} !== 3'b110) begin
      bad++; $display("FAIL rstmid_pre ov/busy/rdy got=%b%b%b want=110", obs.ov, obs.busy, obs.rdy);
    end
    total++;
    @(posedge clk);
    #2 arst_n = 1'b0;
    #1;
    if ({out_valid, busy, in_ready} !== 3'b001) begin
      bad++; $display("FAIL rstmid_async ov/busy/rdy got=%b%b%b want=001", out_valid, busy, in_ready);
    end
    total++;
    q.delete();
    @(negedge clk);
    @(negedge clk);
    arst_n = 1'b1;
    for (int k = 0; k < LAT + 4; k++) begin
      step(0, 0, 0, 0, 1, 0, 0);
      if (obs !== exp) begin bad++; $display("FAIL rstmid_cyc%0d got=%h want=%h", k, obs, exp); end
      total++;
    end
    if (popped.size() != 0) begin
      bad++; $display("FAIL rstmid_stale got=%0d results want=0", popped.size());
    end
    total++;
  endtask

`ifdef FPU_ADDSUB_TAG_EN
  task automatic test_tags();
    logic [3:0] tags [3] = '{4'h3, 4'hA, 4'h5};
    int         sent = 0;
    popped.delete();
    popped_tag.delete();
    for (int k = 0; k < LAT + 8; k++) begin
      if (sent < 3) step(1, r2f(real'(sent + 2)), 32'h3F800000, 0, 1, 0, tags[sent]);
      else          step(0, 0, 0, 0, 1, 0, 4'hF);
      if (obs !== exp) begin bad++; $display("FAIL tag_cyc%0d got=%h want=%h", k, obs, exp); end
      total++;
      if (obs.en) sent++;
    end
    for (int i = 0; i < 3; i++) begin
      if (i >= popped_tag.size() || popped_tag[i] !== tags[i]) begin
        bad++; $display("FAIL tag_order%0d got=%h want=%h", i,
                        i < popped_tag.size() ? popped_tag[i] : 4'hx, tags[i]);
      end
      total++;
    end
  endtask
`endif

  initial begin
    test_reset();
    test_single_add();
    test_single_sub();
    test_back_to_back();
    test_stream();
    test_flush();
    test_reset_mid();
`ifdef FPU_ADDSUB_TAG_EN
    test_tags();
`endif
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
